pic_irr_latch: RTL and testbench
================================

// Module: pic_irr_latch
// PURPOSE
// - Interrupt Request Register stage of the 8259A-compatible PIC: synchronises IR0-IR7, applies edge/level sensing (LTIM).
// - Holds pending requests and drives the masked-priority resolver's IRR input.
// - Clears the acknowledged bit on the first INTA using the resolver's one-hot ISR_IRR.
// - Freezes the resolver-facing IRR for the whole INTA sequence so the vector stays stable.
// PARAMETERS
// - N_IR         8   number of interrupt request lines
// - SYNC_STAGES  2   flip-flop stages in each IR input synchroniser (>=2)
// PORTS
// - clk          in   1      single system clock, all state on rising edge
// - reset        in   1      synchronous, active-high; clears all state
// - ir           in   N_IR   asynchronous IR pins, active-high
// - ltim         in   1      ICW1.LTIM: 1=level-triggered, 0=edge-triggered
// - icw1_write   in   1      1-cycle pulse; ICW1 written, re-initialise IRR
// - inta_1       in   1      1-cycle pulse; first INTA from control
// - inta_2       in   1      1-cycle pulse; second (final) INTA from control
// - isr_irr      in   N_IR   one-hot acked line from priority resolver (valid while inta_1=1)
// - irr          out  N_IR   request register to resolver (frozen during ack)
// - irr_live     out  N_IR   unfrozen register, for OCW3 read-IRR
// - ack_busy     out  1      1 while the INTA sequence is in progress
// BEHAVIOUR
// - Reset: irr=0, irr_live=0, ack_busy=0, sync/edge history=0, FSM=IDLE. The same clear applies on icw1_write (one cycle).
// - Sync: s[i] = ir[i] delayed by SYNC_STAGES clocks; p[i] = s[i] from the previous cycle.
// - Edge mode (ltim=0):
//   - set[i] = s[i] & ~p[i].
//   - The bit stays set while s[i]=1.
//   - s[i]=0 before ack clears it (request withdrawn).
// - Level mode (ltim=1): set[i] = s[i]. The bit tracks level, i.e. is 0 whenever s[i]=0.
// - Ack clear: on the inta_1 cycle, clr = isr_irr. Next cycle irr_live[i] &= ~clr[i].
// - Same cycle set[i] & clr[i] -> set wins (bit stays 1); a new edge is never lost.
// - In level mode, an acked line still high re-sets the bit the cycle after the clear (re-request, as 8259A).
// - FSM (state in pic_pkg):
//   - IDLE -inta_1-> ACK1: snapshot irr <= irr_live_next (already clr-applied); ack_busy=1.
//   - ACK1 -inta_2-> ACK2: irr held.
//   - ACK2 -> IDLE (unconditional, 1 cycle): irr resumes following irr_live; ack_busy=0.
//   - inta_1 while not IDLE: ignored.
//   - inta_2 while IDLE: ignored.
//   - inta_1 & inta_2 same cycle in IDLE: treat as inta_1 only.
// - Outside ACK1/ACK2: irr = irr_live (registered, 0 extra latency). Pin-to-irr latency is SYNC_STAGES+1 clocks.
// - During ACK1/ACK2: irr_live keeps latching new requests/withdrawals; irr does not change.
// - Reset or icw1_write mid-sequence: immediate return to IDLE, all outputs 0 next cycle; pending inta_2 ignored.
// - ltim change: takes effect next cycle. The edge history p is kept, so no false edge for a line already high.
// - All-zero isr_irr on inta_1 (spurious, resolver defaults IR7 one-hot): the clear still applies as given; no special case.
// STRUCTURE
// - pic_pkg: N_IR default, ack_state_t {IDLE,ACK1,ACK2}, LTIM_EDGE/LTIM_LEVEL constants.
// - Sub-module pic_ir_sync: per-bit SYNC_STAGES flop chain with reset, instantiated once N_IR wide.
// - Top holds the edge history, irr_live, snapshot register and ack FSM.
// TESTING
// - Edge (ltim=0): ir[3] 0->1 held -> irr=8'h08 after 3 clks. inta_1 with isr_irr=8'h08 -> irr_live=0 next clk; irr stays 8'h08 until ACK2 -> 0.
// - Edge withdraw: ir[5] pulse 1 for 4 clks then 0, no INTA -> irr 8'h20 then 8'h00 3 clks after fall.
// - Level (ltim=1): ir[1] held high; ack 8'h02 -> irr_live 0 for one clk then 8'h02 again. irr stays frozen through ACK2.
// - Freeze: irr=8'h10, inta_1 (isr_irr=8'h10), ir[0] rises during ACK1 -> irr=8'h00 until IDLE, then 8'h01.
// - Simultaneous: edge on ir[2] reaching s on the inta_1 cycle with isr_irr=8'h04 -> irr_live[2] stays 1.
// - Reset/icw1_write in ACK1 with irr_live=8'hFF -> all outputs 0, ack_busy=0 next clk; following inta_2 has no effect.

Source files
------------

// File: rtl/pic_irr_latch_pkg.sv
// Shared types and constants for the 8259A-compatible interrupt request register stage.
// Imported by the IR synchroniser and the IRR latch top.
package pic_irr_latch_pkg;

    localparam int N_IR_DEF        = 8;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic LTIM_EDGE  = 1'b0;
    localparam logic LTIM_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } ack_state_t;

    // Next pending state for one register bit, shared by edge and level sensing.
    function automatic logic irr_bit_next(
        input logic ltim,
        input logic s,
        input logic p,
        input logic live,
        input logic clr
    );
        logic nxt;
        if (ltim == LTIM_LEVEL) begin
            nxt = s & ~clr;
        end else begin
            nxt = (s & ~p) | (live & s & ~clr);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pic_irr_latch_sync.sv
// Multi-stage synchroniser for the asynchronous IR pins; one flop chain per bit.
// The clear input wipes the whole chain so re-initialisation never replays stale levels.
module pic_ir_sync
    import pic_irr_latch_pkg::*;
#(
    parameter int WIDTH  = N_IR_DEF,
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/pic_irr_latch.sv
// Interrupt request register of the PIC: edge/level sensing, ack clear on first INTA,
// and a frozen resolver-facing copy held for the whole INTA sequence.
//
// state | meaning
// IDLE  | no acknowledge in progress, irr follows irr_live
// ACK1  | first INTA taken, irr frozen, waiting for second INTA
// ACK2  | second INTA taken, irr frozen for one last cycle
module pic_irr_latch
    import pic_irr_latch_pkg::*;
#(
    parameter int N_IR        = N_IR_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N_IR-1:0] ir_i,
    input  logic            ltim_i,
    input  logic            icw1_write_i,
    input  logic            inta_1_i,
    input  logic            inta_2_i,
    input  logic [N_IR-1:0] isr_irr_i,
    output logic [N_IR-1:0] irr_o,
    output logic [N_IR-1:0] irr_live_o,
    output logic            ack_busy_o
);

    logic            clear;
    logic [N_IR-1:0] s;
    logic [N_IR-1:0] p_q;
    logic [N_IR-1:0] clr;
    logic [N_IR-1:0] irr_live_q;
    logic [N_IR-1:0] irr_live_d;
    logic [N_IR-1:0] irr_q;
    logic            ack_busy_q;
    logic            start_ack;
    ack_state_t      state_q;

    assign clear = reset_i | icw1_write_i;

    pic_ir_sync #(
        .WIDTH  (N_IR),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .clear_i (clear),
        .d_i     (ir_i),
        .q_o     (s)
    );

    // An INTA pulse outside IDLE is ignored, so it must not clear anything either.
    assign start_ack = (state_q == IDLE) & inta_1_i;

    always_comb begin
        clr        = '0;
        irr_live_d = '0;
        if (start_ack) begin
            clr = isr_irr_i;
        end
        for (int i = 0; i < N_IR; i++) begin
            irr_live_d[i] = irr_bit_next(ltim_i, s[i], p_q[i], irr_live_q[i], clr[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            p_q        <= '0;
            irr_live_q <= '0;
        end else begin
            p_q        <= s;
            irr_live_q <= irr_live_d;
        end
    end

    // The snapshot taken on inta_1 already has the acked bit removed.
    always_ff @(posedge clk_i) begin
        if (clear) begin
            state_q    <= IDLE;
            irr_q      <= '0;
            ack_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    irr_q <= irr_live_d;
                    if (inta_1_i) begin
                        state_q    <= ACK1;
                        ack_busy_q <= 1'b1;
                    end
                end
                ACK1: begin
                    if (inta_2_i) begin
                        state_q <= ACK2;
                    end
                end
                ACK2: begin
                    state_q    <= IDLE;
                    ack_busy_q <= 1'b0;
                    irr_q      <= irr_live_d;
                end
                default: begin
                    state_q    <= IDLE;
                    ack_busy_q <= 1'b0;
                    irr_q      <= irr_live_d;
                end
            endcase
        end
    end

    assign irr_o      = irr_q;
    assign irr_live_o = irr_live_q;
    assign ack_busy_o = ack_busy_q;

endmodule

// File: tb/tb_pic_irr_latch.sv
// Directed bench for pic_irr_latch: stimulus schedules expected outputs per cycle,
// an independent monitor compares them one clock-sample at a time.
module tb_pic_irr_latch;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] ir_i = 8'h00;
    logic       ltim_i = 1'b0;
    logic       icw1_write_i = 1'b0;
    logic       inta_1_i = 1'b0;
    logic       inta_2_i = 1'b0;
    logic [7:0] isr_irr_i = 8'h00;
    logic [7:0] irr_o;
    logic [7:0] irr_live_o;
    logic       ack_busy_o;

    pic_irr_latch #(.N_IR(8), .SYNC_STAGES(2)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .ir_i         (ir_i),
        .ltim_i       (ltim_i),
        .icw1_write_i (icw1_write_i),
        .inta_1_i     (inta_1_i),
        .inta_2_i     (inta_2_i),
        .isr_irr_i    (isr_irr_i),
        .irr_o        (irr_o),
        .irr_live_o   (irr_live_o),
        .ack_busy_o   (ack_busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] irr;
        logic [7:0] live;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Expected entry for k rising edges from now, kept sorted by cycle.
    task automatic chk(input int k, input string nm, input logic [7:0] e_irr,
                       input logic [7:0] e_live, input logic e_busy);
        exp_t e;
        int   idx;
        e.cyc  = cyc + k;
        e.name = nm;
        e.irr  = e_irr;
        e.live = e_live;
        e.busy = e_busy;
        idx = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc > e.cyc) begin
                idx = i;
                break;
            end
        end
        q.insert(idx, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    always @(posedge clk_i) begin
        exp_t e;
        #1;
        cyc = cyc + 1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s stale entry for cycle %0d at cycle %0d", e.name, e.cyc, cyc);
            end else begin
                n_checks++;
                if (irr_o !== e.irr) begin
                    n_fail++;
                    $display("FAIL %s.irr cyc=%0d actual=%h expected=%h", e.name, cyc, irr_o, e.irr);
                end
                n_checks++;
                if (irr_live_o !== e.live) begin
                    n_fail++;
                    $display("FAIL %s.irr_live cyc=%0d actual=%h expected=%h", e.name, cyc, irr_live_o, e.live);
                end
                n_checks++;
                if (ack_busy_o !== e.busy) begin
                    n_fail++;
                    $display("FAIL %s.ack_busy cyc=%0d actual=%b expected=%b", e.name, cyc, ack_busy_o, e.busy);
                end
            end
        end
    end

    initial begin
        // reset
        tick(1);
        chk(1, "reset", 8'h00, 8'h00, 1'b0);
        tick(1);
        reset_i = 1'b0;
        tick(2);

        // edge: ir[3] held, then ack
        ltim_i = 1'b0;
        ir_i   = 8'h08;
        chk(2, "edge_lat2", 8'h00, 8'h00, 1'b0);
        chk(3, "edge_lat3", 8'h08, 8'h08, 1'b0);
        tick(3);
        inta_1_i = 1'b1; isr_irr_i = 8'h08;
        chk(1, "edge_ack1", 8'h00, 8'h00, 1'b1);
        tick(1);
        inta_1_i = 1'b0; isr_irr_i = 8'h00;
        chk(1, "edge_ack1_hold", 8'h00, 8'h00, 1'b1);
        tick(1);
        inta_2_i = 1'b1;
        chk(1, "edge_ack2", 8'h00, 8'h00, 1'b1);
        tick(1);
        inta_2_i = 1'b0;
        chk(1, "edge_idle", 8'h00, 8'h00, 1'b0);
        tick(1);
        ir_i = 8'h00;
        chk(3, "edge_settle", 8'h00, 8'h00, 1'b0);
        tick(4);

        // edge withdraw
        ir_i = 8'h20;
        chk(3, "wd_set", 8'h20, 8'h20, 1'b0);
        tick(4);
        ir_i = 8'h00;
        chk(2, "wd_still", 8'h20, 8'h20, 1'b0);
        chk(3, "wd_clear", 8'h00, 8'h00, 1'b0);
        tick(3);

        // level: re-request after ack
        ltim_i = 1'b1;
        ir_i   = 8'h02;
        chk(3, "lvl_set", 8'h02, 8'h02, 1'b0);
        tick(3);
        inta_1_i = 1'b1; isr_irr_i = 8'h02;
        chk(1, "lvl_ack1", 8'h00, 8'h00, 1'b1);
        chk(2, "lvl_rereq", 8'h00, 8'h02, 1'b1);
        tick(1);
        inta_1_i = 1'b0; isr_irr_i = 8'h00;
        tick(1);
        inta_2_i = 1'b1;
        chk(1, "lvl_ack2", 8'h00, 8'h02, 1'b1);
        tick(1);
        inta_2_i = 1'b0;
        chk(1, "lvl_idle", 8'h02, 8'h02, 1'b0);
        tick(1);
        // back to edge mode: held line keeps its bit, no false edge, then withdraws
        ir_i   = 8'h00;
        ltim_i = 1'b0;
        chk(2, "ltim_sw_hold", 8'h02, 8'h02, 1'b0);
        chk(3, "ltim_sw_clear", 8'h00, 8'h00, 1'b0);
        tick(3);

        // freeze: new request during ACK1
        ir_i = 8'h10;
        chk(3, "frz_set", 8'h10, 8'h10, 1'b0);
        tick(3);
        inta_1_i = 1'b1; isr_irr_i = 8'h10;
        chk(1, "frz_ack1", 8'h00, 8'h00, 1'b1);
        tick(1);
        inta_1_i = 1'b0; isr_irr_i = 8'h00;
        ir_i = 8'h11;
        chk(1, "frz_a", 8'h00, 8'h00, 1'b1);
        chk(2, "frz_b", 8'h00, 8'h00, 1'b1);
        chk(3, "frz_live", 8'h00, 8'h01, 1'b1);
        tick(3);
        inta_2_i = 1'b1;
        chk(1, "frz_ack2", 8'h00, 8'h01, 1'b1);
        tick(1);
        inta_2_i = 1'b0;
        chk(1, "frz_idle", 8'h01, 8'h01, 1'b0);
        tick(1);
        ir_i = 8'h00;
        chk(3, "frz_settle", 8'h00, 8'h00, 1'b0);
        tick(4);

        // simultaneous set and clear on ir[2]
        ir_i = 8'h04;
        tick(2);
        inta_1_i = 1'b1; isr_irr_i = 8'h04;
        chk(1, "sim_ack1", 8'h04, 8'h04, 1'b1);
        tick(1);
        inta_1_i = 1'b0; isr_irr_i = 8'h00; inta_2_i = 1'b1;
        chk(1, "sim_ack2", 8'h04, 8'h04, 1'b1);
        tick(1);
        inta_2_i = 1'b0;
        chk(1, "sim_idle", 8'h04, 8'h04, 1'b0);
        tick(1);

        // icw1_write in ACK1 with all lines pending, spurious all-zero ack
        ir_i = 8'hFF;
        chk(3, "all_set", 8'hFF, 8'hFF, 1'b0);
        tick(3);
        inta_1_i = 1'b1; isr_irr_i = 8'h00;
        chk(1, "icw_ack1", 8'hFF, 8'hFF, 1'b1);
        tick(1);
        inta_1_i = 1'b0; icw1_write_i = 1'b1;
        chk(1, "icw_clear", 8'h00, 8'h00, 1'b0);
        tick(1);
        icw1_write_i = 1'b0; inta_2_i = 1'b1;
        chk(1, "icw_inta2_ign", 8'h00, 8'h00, 1'b0);
        tick(1);
        inta_2_i = 1'b0;
        chk(1, "icw_resync_a", 8'h00, 8'h00, 1'b0);
        chk(2, "icw_resync_b", 8'hFF, 8'hFF, 1'b0);
        tick(2);

        // reset in ACK1
        inta_1_i = 1'b1; isr_irr_i = 8'h00;
        chk(1, "rst_ack1", 8'hFF, 8'hFF, 1'b1);
        tick(1);
        inta_1_i = 1'b0; reset_i = 1'b1;
        chk(1, "rst_clear", 8'h00, 8'h00, 1'b0);
        tick(1);
        reset_i = 1'b0; inta_2_i = 1'b1;
        chk(1, "rst_inta2_ign", 8'h00, 8'h00, 1'b0);
        tick(1);
        inta_2_i = 1'b0;
        chk(1, "rst_resync_a", 8'h00, 8'h00, 1'b0);
        chk(2, "rst_resync_b", 8'hFF, 8'hFF, 1'b0);
        tick(2);

        // inta_1 and inta_2 together in IDLE, then inta_1 while busy
        inta_1_i = 1'b1; inta_2_i = 1'b1; isr_irr_i = 8'h80;
        chk(1, "both_ack1", 8'h7F, 8'h7F, 1'b1);
        tick(1);
        inta_1_i = 1'b0; inta_2_i = 1'b0; isr_irr_i = 8'h00;
        chk(1, "both_stay_ack1", 8'h7F, 8'h7F, 1'b1);
        tick(1);
        inta_1_i = 1'b1; isr_irr_i = 8'h01;
        chk(1, "busy_inta1_ign", 8'h7F, 8'h7F, 1'b1);
        tick(1);
        inta_1_i = 1'b0; isr_irr_i = 8'h00; inta_2_i = 1'b1;
        chk(1, "both_ack2", 8'h7F, 8'h7F, 1'b1);
        tick(1);
        inta_2_i = 1'b0;
        chk(1, "both_idle", 8'h7F, 8'h7F, 1'b0);
        tick(1);
        ir_i = 8'h00;

        for (int i = 0; i < 50 && q.size() > 0; i++) begin
            tick(1);
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain %0d expected entries left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
